// File: rtl/key_uart_bridge.sv
// key_uart_bridge: queues keyboard bytes into uart_tx and keeps a history of received UART bytes.
// Optional feature KEY_UART_ECHO_EN also echoes each received byte back through the TX FIFO.
module key_uart_bridge #(
  parameter int DEPTH = 16,
  parameter int HIST = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [7:0]               key_byte,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     tx_active,
  input  logic                     tx_done,
  output logic                     tx_wr,
  output logic [7:0]               tx_byte,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [8*HIST-1:0]        disp_value,
  output logic [7:0]               rx_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SEND, BUSY} state_t;
  state_t state, state_n;
  logic key_q, rx_q, key_ev, rx_ev;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, pop, push, wr, lost;
  logic [7:0] push_byte;
  assign key_ev = key_valid & ~key_q;
  assign rx_ev = rx_valid & ~rx_q;
  assign full = fifo_count == (AW+1)'(DEPTH);
  assign pop = state == IDLE && fifo_count != '0 && !tx_active;
  assign wr = push & (~full | pop);
`ifdef KEY_UART_ECHO_EN
  logic pend_v;
  logic [7:0] pend_b;
  // the pending rx byte only reaches the FIFO in a cycle without a key event
  assign push = key_ev | pend_v;
  assign push_byte = key_ev ? key_byte : pend_b;
  assign lost = (push & full & ~pop) | (rx_ev & pend_v);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_v <= 1'b0;
      pend_b <= '0;
    end else if (rx_ev) begin
      pend_v <= 1'b1;
      pend_b <= rx_byte;
    end else if (!key_ev) begin
      pend_v <= 1'b0;
    end
`else
  assign push = key_ev;
  assign push_byte = key_byte;
  assign lost = push & full & ~pop;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (pop ? SEND : IDLE) :
              state == SEND ? BUSY :
              (tx_done ? IDLE : BUSY);
  always_comb tx_wr = state == SEND;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= push_byte;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_q <= 1'b0;
      rx_q <= 1'b0;
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      tx_byte <= '0;
      disp_value <= '0;
      rx_count <= '0;
    end else begin
      key_q <= key_valid;
      rx_q <= rx_valid;
      if (wr) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        tx_byte <= mem[rp];
      end
      fifo_count <= fifo_count + (AW+1)'(wr) - (AW+1)'(pop);
      if (lost) overflow <= 1'b1;
      if (rx_ev) begin
        disp_value <= (disp_value << 8) | (8*HIST)'(rx_byte);
        rx_count <= rx_count + 8'd1;
      end
    end
endmodule

// File: tb/tb_key_uart_bridge.sv
// tb_key_uart_bridge: scoreboard bench; expected TX bytes are queued at stimulus time and
// popped by a monitor on every tx_wr, while a UART model answers with random-latency tx_done.
module tb_key_uart_bridge;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, key_valid = 0, rx_valid = 0, tx_done = 0;
  logic hold_active = 0, u_busy = 0, auto_done = 1;
  logic [7:0] key_byte = 0, rx_byte = 0;
  logic tx_active, tx_wr, overflow;
  logic [7:0] tx_byte, rx_count;
  logic [4:0] fifo_count;
  logic [15:0] disp_value;
  int errors = 0, checks = 0, wr_count = 0, snap;
  logic [7:0] exp_q[$];
  logic [15:0] m_disp = 0;
  logic [7:0] m_cnt = 0;
  logic prev_wr = 0;
  assign tx_active = hold_active | u_busy;
  always #5 clk = ~clk;
  key_uart_bridge #(.DEPTH(DEPTH), .HIST(2)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_byte(key_byte),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .tx_wr(tx_wr), .tx_byte(tx_byte), .fifo_count(fifo_count), .overflow(overflow),
    .disp_value(disp_value), .rx_count(rx_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && tx_wr) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_wr: got tx_byte %0h expected no transmit", tx_byte);
      end else chk("tx_byte_order", 32'(tx_byte), 32'(exp_q.pop_front()));
      if (prev_wr) begin
        checks++;
        errors++;
        $display("FAIL tx_wr_width: got 2+ cycles expected 1");
      end
    end
    prev_wr <= tx_wr;
  end
  initial forever begin
    @(negedge clk);
    if (tx_wr && auto_done && !rst) begin
      u_busy = 1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      u_busy = 0;
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
    end
  end
  task automatic ev(input logic dk, input logic [7:0] kb, input logic dr, input logic [7:0] rb);
    key_valid = dk;
    key_byte = kb;
    rx_valid = dr;
    rx_byte = rb;
    if (dk) exp_q.push_back(kb);
    if (dr) begin
      m_disp = {m_disp[7:0], rb};
      m_cnt++;
`ifdef KEY_UART_ECHO_EN
      exp_q.push_back(rb);
`endif
    end
    @(negedge clk);
    if (dr) begin
      chk("disp_value", 32'(disp_value), 32'(m_disp));
      chk("rx_count", 32'(rx_count), 32'(m_cnt));
    end
    key_valid = 0;
    rx_valid = 0;
    @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(negedge clk);
    chk("fifo_count_drained", 32'(fifo_count), 0);
  endtask
  task automatic settle();
`ifdef KEY_UART_ECHO_EN
    drain();
`endif
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_tx_wr"}, 32'(tx_wr), 0);
    chk({tag, "_tx_byte"}, 32'(tx_byte), 0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_disp_value"}, 32'(disp_value), 0);
    chk({tag, "_rx_count"}, 32'(rx_count), 0);
  endtask
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1;
    #1 check_zero("async_rst");
    exp_q.delete();
    m_disp = 0;
    m_cnt = 0;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 0;
    @(negedge clk);
    key_byte = 8'h1C;
    key_valid = 1;
    exp_q.push_back(8'h1C);
    @(negedge clk);
    chk("lat_count_after_e0", 32'(fifo_count), 1);
    chk("lat_no_wr_at_e0", 32'(tx_wr), 0);
    @(negedge clk);
    chk("lat_wr_at_e1", 32'(tx_wr), 1);
    chk("lat_tx_byte", 32'(tx_byte), 32'h1C);
    chk("lat_count_after_e1", 32'(fifo_count), 0);
    key_valid = 0;
    drain();
    snap = wr_count;
    ev(1, 8'h1C, 0, 0);
    ev(1, 8'h32, 0, 0);
    ev(1, 8'h21, 0, 0);
    drain();
    chk("one_wr_per_byte", 32'(wr_count - snap), 3);
    ev(0, 0, 1, 8'hA5); settle();
    ev(0, 0, 1, 8'h3C); settle();
    ev(0, 0, 1, 8'h7E); settle();
    chk("disp_3C7E", 32'(disp_value), 32'h3C7E);
    chk("rx_count_3", 32'(rx_count), 3);
    for (int i = 0; i < 256; i++) begin
      ev(0, 0, 1, 8'($urandom));
      settle();
    end
    chk("rx_count_wrap", 32'(rx_count), 3);
    for (int i = 0; i < 12; i++) begin
      ev(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
      settle();
    end
    drain();
    auto_done = 0;
    for (int i = 0; i < 5; i++) ev(1, 8'($urandom), 0, 0);
    chk("queued_in_busy", 32'(fifo_count), 4);
    snap = wr_count;
    async_reset();
    repeat (12) @(negedge clk);
    chk("no_wr_after_rst", 32'(wr_count - snap), 0);
    chk("fifo_empty_after_rst", 32'(fifo_count), 0);
    hold_active = 1;
    auto_done = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      ev(1, 8'($urandom), 0, 0);
      if (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    end
    chk("full_count", 32'(fifo_count), 16);
    chk("overflow_set", 32'(overflow), 1);
    hold_active = 0;
    drain();
    chk("overflow_sticky", 32'(overflow), 1);
    async_reset();
`ifdef KEY_UART_ECHO_EN
    snap = wr_count;
    ev(1, 8'h11, 1, 8'h55);
    drain();
    chk("echo_two_bytes", 32'(wr_count - snap), 2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
